// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter.
// Holds the CorePack memory-op codes, the arbiter state type and the
// grant identifiers used for round-robin bookkeeping.
package mem_arbiter_pkg;

   // Memory operation codes (width in low two bits, bit 2 = unsigned load).
   localparam logic [2:0] MEM_B  = 3'd0;
   localparam logic [2:0] MEM_H  = 3'd1;
   localparam logic [2:0] MEM_W  = 3'd2;
   localparam logic [2:0] MEM_D  = 3'd3;
   localparam logic [2:0] MEM_UB = 3'd4;
   localparam logic [2:0] MEM_UH = 3'd5;
   localparam logic [2:0] MEM_UW = 3'd6;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      I_WAIT = 2'd1,
      D_WAIT = 2'd2,
      RESP   = 2'd3
   } arb_state_t;

   localparam logic GRANT_IF = 1'b0;
   localparam logic GRANT_DM = 1'b1;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane formatter for data-memory accesses.
// Ports:
//   memop, we, offset  - access description (offset = byte address bits [2:0])
//   wdata              - right-justified store data
//   rdata              - raw 64-bit memory read data
//   wdata_sh, wmask    - lane-shifted store data and byte enables (0 for loads)
//   rdata_ext          - extracted and sign/zero-extended load data
//   misalign, illegal  - access not naturally aligned / op not allowed
module mem_lane_align
   import mem_arbiter_pkg::*;
(
   input  logic [2:0]  memop,
   input  logic        we,
   input  logic [2:0]  offset,
   input  logic [63:0] wdata,
   input  logic [63:0] rdata,
   output logic [63:0] wdata_sh,
   output logic [7:0]  wmask,
   output logic [63:0] rdata_ext,
   output logic        misalign,
   output logic        illegal
);

   logic [5:0]  bit_off;
   logic [63:0] rsh;

   always_comb begin
      wdata_sh  = '0;
      wmask     = '0;
      rdata_ext = '0;
      misalign  = 1'b0;
      illegal   = 1'b0;
      bit_off   = {offset, 3'b000};
      rsh       = rdata >> bit_off;

      case (memop)
         MEM_B: begin
            wmask     = 8'h01 << offset;
            rdata_ext = {{56{rsh[7]}}, rsh[7:0]};
         end
         MEM_UB: begin
            illegal   = we;
            rdata_ext = {56'b0, rsh[7:0]};
         end
         MEM_H: begin
            misalign  = offset[0];
            wmask     = 8'h03 << offset;
            rdata_ext = {{48{rsh[15]}}, rsh[15:0]};
         end
         MEM_UH: begin
            misalign  = offset[0];
            illegal   = we;
            rdata_ext = {48'b0, rsh[15:0]};
         end
         MEM_W: begin
            misalign  = (offset[1:0] != 2'b00);
            wmask     = 8'h0F << offset;
            rdata_ext = {{32{rsh[31]}}, rsh[31:0]};
         end
         MEM_UW: begin
            misalign  = (offset[1:0] != 2'b00);
            illegal   = we;
            rdata_ext = {32'b0, rsh[31:0]};
         end
         MEM_D: begin
            misalign  = (offset != 3'b000);
            wmask     = 8'hFF;
            rdata_ext = rdata;
         end
         default: illegal = 1'b1;
      endcase

      if (we) begin
         wdata_sh = wdata << bit_off;
      end else begin
         wmask = '0;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one 64-bit memory port between instruction fetch (IF)
// and data memory (DM). One transaction at a time, round-robin on contest,
// misaligned/illegal accesses answered with err without a memory access.
// Ports:
//   clk, rst                    - clock, async active-high reset
//   if_req/if_addr              - fetch request; if_ack/if_err/if_rdata response
//   dm_req/dm_we/dm_memop/
//   dm_addr/dm_wdata            - data request; dm_ack/dm_err/dm_rdata response
//   mem_req/mem_we/mem_addr/
//   mem_wdata/mem_wmask         - registered memory request, held until mem_ack
//   mem_rdata/mem_ack           - memory response
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W = 64
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ack,
   output logic              if_err,
   output logic [31:0]       if_rdata,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [2:0]        dm_memop,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [63:0]       dm_wdata,
   output logic              dm_ack,
   output logic              dm_err,
   output logic [63:0]       dm_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [63:0]       mem_wdata,
   output logic [7:0]        mem_wmask,
   input  logic [63:0]       mem_rdata,
   input  logic              mem_ack
);

   arb_state_t  state, state_nx;
   logic        last_grant, last_grant_nx;
   logic        resp_nx, err_nx;
   logic        load_if, load_dm;
   logic [2:0]  op_q, off_q;

   logic [2:0]  al_memop, al_off;
   logic        al_we;
   logic [63:0] al_wdata_sh, al_rdata_ext;
   logic [7:0]  al_wmask;
   logic        al_misalign, al_illegal;

   // The aligner checks the live DM request at grant time and formats read
   // data from the registered op/offset while the DM transaction is pending.
   always_comb begin
      al_memop = dm_memop;
      al_we    = dm_we;
      al_off   = dm_addr[2:0];
      if (state == D_WAIT) begin
         al_memop = op_q;
         al_we    = mem_we;
         al_off   = off_q;
      end
   end

   mem_lane_align u_align (
      .memop     (al_memop),
      .we        (al_we),
      .offset    (al_off),
      .wdata     (dm_wdata),
      .rdata     (mem_rdata),
      .wdata_sh  (al_wdata_sh),
      .wmask     (al_wmask),
      .rdata_ext (al_rdata_ext),
      .misalign  (al_misalign),
      .illegal   (al_illegal)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= GRANT_IF;
      end else begin
         state      <= state_nx;
         last_grant <= last_grant_nx;
      end
   end

   // last_grant always names the owner of the current WAIT/RESP, so it also
   // selects which requester receives the ack.
   always_comb begin
      state_nx      = state;
      last_grant_nx = last_grant;
      resp_nx       = 1'b0;
      err_nx        = 1'b0;
      load_if       = 1'b0;
      load_dm       = 1'b0;
      case (state)
         IDLE: begin
            if (dm_req && (!if_req || last_grant == GRANT_IF)) begin
               last_grant_nx = GRANT_DM;
               if (al_misalign || al_illegal) begin
                  state_nx = RESP;
                  resp_nx  = 1'b1;
                  err_nx   = 1'b1;
               end else begin
                  state_nx = D_WAIT;
                  load_dm  = 1'b1;
               end
            end else if (if_req) begin
               last_grant_nx = GRANT_IF;
               if (if_addr[1:0] != 2'b00) begin
                  state_nx = RESP;
                  resp_nx  = 1'b1;
                  err_nx   = 1'b1;
               end else begin
                  state_nx = I_WAIT;
                  load_if  = 1'b1;
               end
            end
         end
         I_WAIT, D_WAIT: begin
            if (mem_ack) begin
               state_nx = RESP;
               resp_nx  = 1'b1;
            end
         end
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_wmask <= '0;
         op_q      <= '0;
         off_q     <= '0;
         if_ack    <= 1'b0;
         if_err    <= 1'b0;
         if_rdata  <= '0;
         dm_ack    <= 1'b0;
         dm_err    <= 1'b0;
         dm_rdata  <= '0;
      end else begin
         mem_req <= (state_nx == I_WAIT) || (state_nx == D_WAIT);

         if (load_if) begin
            mem_we    <= 1'b0;
            mem_addr  <= {if_addr[ADDR_W-1:3], 3'b000};
            mem_wdata <= '0;
            mem_wmask <= '0;
            op_q      <= MEM_W;
            off_q     <= if_addr[2:0];
         end else if (load_dm) begin
            mem_we    <= dm_we;
            mem_addr  <= {dm_addr[ADDR_W-1:3], 3'b000};
            mem_wdata <= al_wdata_sh;
            mem_wmask <= al_wmask;
            op_q      <= dm_memop;
            off_q     <= dm_addr[2:0];
         end

         if_ack   <= resp_nx && (last_grant_nx == GRANT_IF);
         if_err   <= resp_nx && (last_grant_nx == GRANT_IF) && err_nx;
         dm_ack   <= resp_nx && (last_grant_nx == GRANT_DM);
         dm_err   <= resp_nx && (last_grant_nx == GRANT_DM) && err_nx;

         if_rdata <= '0;
         dm_rdata <= '0;
         if (resp_nx && !err_nx) begin
            if (last_grant_nx == GRANT_IF) begin
               if_rdata <= off_q[2] ? mem_rdata[63:32] : mem_rdata[31:0];
            end else if (!mem_we) begin
               dm_rdata <= al_rdata_ext;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed table, randomized
// transactions against a reference model, and hand-written sequences for
// arbitration order and reset during a pending transaction.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [63:0] if_addr;
   logic        if_ack, if_err;
   logic [31:0] if_rdata;
   logic        dm_req, dm_we;
   logic [2:0]  dm_memop;
   logic [63:0] dm_addr, dm_wdata;
   logic        dm_ack, dm_err;
   logic [63:0] dm_rdata;
   logic        mem_req, mem_we;
   logic [63:0] mem_addr, mem_wdata;
   logic [7:0]  mem_wmask;
   logic [63:0] mem_rdata;
   logic        mem_ack;

   int unsigned errors = 0;
   int unsigned checks = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(64)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_err(if_err), .if_rdata(if_rdata),
      .dm_req(dm_req), .dm_we(dm_we), .dm_memop(dm_memop), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_ack(dm_ack), .dm_err(dm_err), .dm_rdata(dm_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wmask(mem_wmask), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   typedef struct {
      logic        is_if;
      logic        we;
      logic [2:0]  op;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [63:0] rdata;
      int unsigned delay;
      logic        exp_err;
      logic [63:0] exp_maddr;
      logic [7:0]  exp_mask;
      logic [63:0] exp_wdata;
      logic [63:0] exp_rdata;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic is_if, input logic we, input logic [2:0] op,
                               input logic [63:0] addr, input logic [63:0] wdata,
                               input logic [63:0] rdata, input int unsigned delay,
                               input logic err, input logic [63:0] maddr, input logic [7:0] mask,
                               input logic [63:0] wd, input logic [63:0] rd);
      vec_t v;
      v.is_if = is_if; v.we = we; v.op = op; v.addr = addr; v.wdata = wdata;
      v.rdata = rdata; v.delay = delay; v.exp_err = err; v.exp_maddr = maddr;
      v.exp_mask = mask; v.exp_wdata = wd; v.exp_rdata = rd;
      return v;
   endfunction

   // Reference model: expected results derived from access size and byte offset.
   function automatic vec_t model(input vec_t v);
      vec_t        r = v;
      int unsigned off, size;
      logic        uns, illegal;
      logic [63:0] sh, keep;
      off = int'(v.addr % 64'd8);
      r.exp_maddr = v.addr - 64'(off);
      r.exp_mask  = 8'h00;
      r.exp_wdata = 64'h0;
      r.exp_rdata = 64'h0;
      if (v.is_if) begin
         r.exp_err = (v.addr % 64'd4) != 64'd0;
         if (!r.exp_err)
            r.exp_rdata = ((v.addr / 64'd4) % 64'd2 == 64'd1) ? (v.rdata >> 32) : (v.rdata & 64'hFFFF_FFFF);
         return r;
      end
      if (v.op == MEM_B || v.op == MEM_UB)      size = 1;
      else if (v.op == MEM_H || v.op == MEM_UH) size = 2;
      else if (v.op == MEM_W || v.op == MEM_UW) size = 4;
      else if (v.op == MEM_D)                   size = 8;
      else                                      size = 0;
      uns     = (v.op == MEM_UB) || (v.op == MEM_UH) || (v.op == MEM_UW);
      illegal = (size == 0) || (v.we && uns);
      r.exp_err = illegal ? 1'b1 : ((off % size) != 0);
      if (r.exp_err) return r;
      if (v.we) begin
         r.exp_mask  = 8'(((1 << size) - 1) << off);
         r.exp_wdata = v.wdata << (8 * off);
      end else begin
         sh = v.rdata >> (8 * off);
         if (size < 8) begin
            keep = (64'd1 << (8 * size)) - 64'd1;
            sh   = sh & keep;
            if (!uns && sh[8*size-1]) sh = sh | ~keep;
         end
         r.exp_rdata = sh;
      end
      return r;
   endfunction

   // Issues one transaction at a negedge in an IDLE-ready cycle and returns
   // at the negedge of the following IDLE cycle.
   task automatic xact(input vec_t v, input string tag);
      logic        ack, err, oack;
      logic [63:0] rd;
      if (v.is_if) begin
         if_req = 1'b1; if_addr = v.addr;
      end else begin
         dm_req = 1'b1; dm_we = v.we; dm_memop = v.op; dm_addr = v.addr; dm_wdata = v.wdata;
      end
      @(negedge clk);
      if (!v.exp_err) begin
         chk({tag, " mem_req"}, mem_req, 1'b1);
         chk({tag, " mem_addr"}, mem_addr, v.exp_maddr);
         chk({tag, " mem_we"}, mem_we, v.we && !v.is_if);
         chk({tag, " mem_wmask"}, mem_wmask, v.exp_mask);
         if (v.we && !v.is_if) chk({tag, " mem_wdata"}, mem_wdata, v.exp_wdata);
         chk({tag, " early ack"}, v.is_if ? if_ack : dm_ack, 1'b0);
         for (int unsigned c = 1; c < v.delay; c++) begin
            @(negedge clk);
            chk({tag, " mem_req held"}, mem_req, 1'b1);
         end
         mem_ack = 1'b1; mem_rdata = v.rdata;
         @(negedge clk);
         mem_ack = 1'b0; mem_rdata = {$urandom(), $urandom()};
      end
      ack  = v.is_if ? if_ack : dm_ack;
      err  = v.is_if ? if_err : dm_err;
      oack = v.is_if ? dm_ack : if_ack;
      rd   = v.is_if ? {32'h0, if_rdata} : dm_rdata;
      chk({tag, " ack"}, ack, 1'b1);
      chk({tag, " err"}, err, v.exp_err);
      chk({tag, " rdata"}, rd, v.exp_rdata);
      chk({tag, " other ack"}, oack, 1'b0);
      chk({tag, " mem_req after"}, mem_req, 1'b0);
      if_req = 1'b0; dm_req = 1'b0;
      @(negedge clk);
      chk({tag, " ack one cycle"}, v.is_if ? if_ack : dm_ack, 1'b0);
   endtask

   // Both requesters raised together: DM is expected first, then IF.
   task automatic contest(input string tag);
      if_req = 1'b1; if_addr = 64'h0;
      dm_req = 1'b1; dm_we = 1'b0; dm_memop = MEM_D; dm_addr = 64'h100;
      @(negedge clk);
      chk({tag, " dm first mem_addr"}, mem_addr, 64'h100);
      chk({tag, " dm first mem_req"}, mem_req, 1'b1);
      mem_ack = 1'b1; mem_rdata = 64'hA5A5_5A5A_0F0F_F0F0;
      @(negedge clk);
      mem_ack = 1'b0;
      chk({tag, " dm_ack"}, dm_ack, 1'b1);
      chk({tag, " if_ack idle"}, if_ack, 1'b0);
      chk({tag, " dm_rdata"}, dm_rdata, 64'hA5A5_5A5A_0F0F_F0F0);
      dm_req = 1'b0;
      @(negedge clk);
      chk({tag, " gap mem_req"}, mem_req, 1'b0);
      @(negedge clk);
      chk({tag, " if second mem_req"}, mem_req, 1'b1);
      chk({tag, " if second mem_addr"}, mem_addr, 64'h0);
      mem_ack = 1'b1; mem_rdata = 64'h1111_2222_3333_4444;
      @(negedge clk);
      mem_ack = 1'b0;
      chk({tag, " if_ack"}, if_ack, 1'b1);
      chk({tag, " if_rdata"}, {32'h0, if_rdata}, 64'h3333_4444);
      chk({tag, " dm_ack idle"}, dm_ack, 1'b0);
      if_req = 1'b0;
      @(negedge clk);
   endtask

   vec_t tbl[15];
   vec_t v;

   initial begin
      rst = 1'b1; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
      dm_memop = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0; mem_ack = 1'b0;

      tbl[0]  = mk(0, 1, MEM_B,  64'h1003, 64'hAB, 64'h0, 2, 0, 64'h1000, 8'h08, 64'hAB00_0000, 64'h0);
      tbl[1]  = mk(0, 0, MEM_H,  64'h2006, 64'h0, 64'h80FF_0000_0000_0000, 1, 0, 64'h2000, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_80FF);
      tbl[2]  = mk(0, 0, MEM_UH, 64'h2006, 64'h0, 64'h80FF_0000_0000_0000, 3, 0, 64'h2000, 8'h00, 64'h0, 64'h80FF);
      tbl[3]  = mk(0, 0, MEM_W,  64'h2, 64'h0, 64'h0, 1, 1, 64'h0, 8'h00, 64'h0, 64'h0);
      tbl[4]  = mk(0, 1, MEM_UB, 64'h10, 64'h55, 64'h0, 1, 1, 64'h10, 8'h00, 64'h0, 64'h0);
      tbl[5]  = mk(1, 0, MEM_W,  64'h6, 64'h0, 64'h0, 1, 1, 64'h0, 8'h00, 64'h0, 64'h0);
      tbl[6]  = mk(1, 0, MEM_W,  64'h104, 64'h0, 64'h1122_3344_5566_7788, 2, 0, 64'h100, 8'h00, 64'h0, 64'h1122_3344);
      tbl[7]  = mk(0, 1, MEM_D,  64'h2008, 64'h0123_4567_89AB_CDEF, 64'h0, 1, 0, 64'h2008, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'h0);
      tbl[8]  = mk(0, 0, MEM_W,  64'h3004, 64'h0, 64'h8000_0000_1234_5678, 1, 0, 64'h3000, 8'h00, 64'h0, 64'hFFFF_FFFF_8000_0000);
      tbl[9]  = mk(0, 0, MEM_UW, 64'h3004, 64'h0, 64'h8000_0000_1234_5678, 1, 0, 64'h3000, 8'h00, 64'h0, 64'h8000_0000);
      tbl[10] = mk(0, 0, MEM_B,  64'h7, 64'h0, 64'h7F00_0000_0000_0000, 4, 0, 64'h0, 8'h00, 64'h0, 64'h7F);
      tbl[11] = mk(0, 0, 3'd7,   64'h40, 64'h0, 64'h0, 1, 1, 64'h40, 8'h00, 64'h0, 64'h0);
      tbl[12] = mk(0, 1, MEM_H,  64'hE, 64'hBEEF, 64'h0, 2, 0, 64'h8, 8'hC0, 64'hBEEF_0000_0000_0000, 64'h0);
      tbl[13] = mk(0, 0, MEM_D,  64'h4, 64'h0, 64'h0, 1, 1, 64'h0, 8'h00, 64'h0, 64'h0);
      tbl[14] = mk(1, 0, MEM_W,  64'h100, 64'h0, 64'h1122_3344_5566_7788, 1, 0, 64'h100, 8'h00, 64'h0, 64'h5566_7788);

      @(negedge clk);
      @(negedge clk);
      chk("reset mem_req", mem_req, 1'b0);
      chk("reset mem_addr", mem_addr, 64'h0);
      chk("reset mem_wmask", mem_wmask, 8'h0);
      chk("reset acks", {62'h0, if_ack, dm_ack}, 64'h0);
      rst = 1'b0;
      @(negedge clk);
      chk("post-reset idle", {61'h0, mem_req, if_ack, dm_ack}, 64'h0);

      contest("contest1");
      contest("contest2");

      for (int i = 0; i < 15; i++) xact(tbl[i], $sformatf("tbl%0d", i));

      for (int i = 0; i < 60; i++) begin
         v.is_if = ($urandom_range(0, 3) == 0);
         v.we    = $urandom_range(0, 1) == 1;
         v.op    = 3'($urandom_range(0, 7));
         v.addr  = {32'h0, 16'($urandom()), 16'($urandom())};
         v.wdata = {$urandom(), $urandom()};
         v.rdata = {$urandom(), $urandom()};
         v.delay = $urandom_range(1, 4);
         v = model(v);
         xact(v, $sformatf("rnd%0d", i));
      end

      // Reset while a DM load is outstanding.
      dm_req = 1'b1; dm_we = 1'b0; dm_memop = MEM_D; dm_addr = 64'h800;
      @(negedge clk);
      chk("midrst mem_req before", mem_req, 1'b1);
      #2 rst = 1'b1;
      #1 chk("midrst mem_req drop", mem_req, 1'b0);
      dm_req = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      chk("midrst stray dm_ack", dm_ack, 1'b0);
      chk("midrst stray if_ack", if_ack, 1'b0);
      chk("midrst stray mem_req", mem_req, 1'b0);
      @(negedge clk);
      chk("midrst quiet", {61'h0, mem_req, if_ack, dm_ack}, 64'h0);
      contest("contest after reset");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the core's single 64-bit memory port between the instruction-fetch requester (IF) and the data-memory requester (DM). Fairly arbitrates and sequences one transaction at a time, and holds each until the memory acknowledges it. Performs byte-lane alignment: store shift and mask, load extract and sign/zero extension per `memop`. Rejects misaligned or illegal accesses without touching memory. Sits between the pipeline's IF/MEM stages and the memory/bus model.

## Interface
- `ADDR_W`, default 64: address width of all address ports.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `if_req`  in  1  IF request; `if_addr` held stable until `if_ack`.
- `if_addr`  in  ADDR_W  fetch byte address.
- `if_ack`  out  1  one-cycle completion pulse.
- `if_err`  out  1  valid with `if_ack`; 1 = misaligned fetch.
- `if_rdata`  out  32  instruction word: `mem_rdata` upper half if `if_addr[2]`, else lower half.
- `dm_req`  in  1  DM request; all `dm_*` inputs held stable until `dm_ack`.
- `dm_we`  in  1  1 = store, 0 = load.
- `dm_memop`  in  3  CorePack `MEM_*` code.
- `dm_addr`  in  ADDR_W  byte address.
- `dm_wdata`  in  64  store data, right-justified.
- `dm_ack`  out  1  one-cycle completion pulse.
- `dm_err`  out  1  valid with `dm_ack`; 1 = misaligned or illegal op.
- `dm_rdata`  out  64  extended load data; 0 for stores and errors.
- `mem_req`  out  1  memory request, held until `mem_ack`.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  ADDR_W  doubleword-aligned address, `{addr[ADDR_W-1:3],3'b0}`.
- `mem_wdata`  out  64  lane-shifted store data.
- `mem_wmask`  out  8  byte-enable mask.
- `mem_rdata`  in  64  read data, valid with `mem_ack`.
- `mem_ack`  in  1  memory completion; sampled only while `mem_req`=1.

## Operation
- States: `IDLE`, `I_WAIT`, `D_WAIT`, `RESP`.
- **IDLE:** samples requests.
  - Only one requester active: grant it.
  - Both active: grant the one not equal to `last_grant`.
  - `last_grant` resets to IF, so DM wins the first contest.
  - `last_grant` updates on every grant, including error grants.
- **Alignment check at grant:**
  - `MEM_D`: `addr[2:0]`=0.
  - `MEM_W`/`MEM_UW`: `addr[1:0]`=0.
  - `MEM_H`/`MEM_UH`: `addr[0]`=0.
  - `MEM_B`/`MEM_UB`: always aligned.
  - IF: `if_addr[1:0]`=0.
- **Illegal DM ops:** store with `MEM_UW`/`MEM_UH`/`MEM_UB`, or any undefined code.
- **Error grant:** goes straight to `RESP` with err=1 and rdata=0; no memory transaction is issued.
- **Legal grant:**
  - Registers address, op and lane data; enters `I_WAIT` or `D_WAIT`.
  - `mem_req`=1 from the next cycle until the cycle `mem_ack`=1, inclusive.
  - On `mem_ack`: capture formatted read data and go to `RESP`.
- **RESP:** asserts the granted requester's ack for exactly one cycle, then `IDLE`. Requesters drop or change their request the cycle after ack.
- **Store lanes:**
  - `off = addr[2:0]`.
  - `mem_wdata = dm_wdata << 8*off`.
  - `mem_wmask`: B = `8'h01<<off`, H = `8'h03<<off`, W = `8'h0F<<off`, D = `8'hFF`.
- **Loads:**
  - `mem_we`=0, `mem_wmask`=0.
  - `dm_rdata`: `mem_rdata >> 8*off`, then sign-extended (B/H/W) or zero-extended (UB/UH/UW). D passes through.
- IF reads always use `mem_we`=0 and `mem_wmask`=0.

## Timing
- **Reset values:** all outputs 0; state `IDLE`; `last_grant`=IF.
- **Reset mid-transaction:** `mem_req` drops immediately and the transaction is abandoned. Any `mem_ack` after release is ignored unless in a WAIT state.
- **Latency:**
  - req sampled at cycle 0 → `mem_req` at 1.
  - `mem_ack` at cycle k≥1 → ack at k+1.
  - Next grant possible at k+2.
  - Error path: ack at cycle 1.
- `mem_ack` in `IDLE`/`RESP` is ignored.
- `mem_*` outputs are registered and constant while `mem_req`=1.
- ack/err/rdata are registered and valid only in the ack cycle; rdata and err are 0 otherwise.
- A request arriving during WAIT/RESP waits, unaffected, until `IDLE`.

## Structure
- CorePack keeps the existing `MEM_*` codes.
- Add to CorePack:
  - `typedef enum logic [1:0] arb_state_t {IDLE, I_WAIT, D_WAIT, RESP}`.
  - `localparam GRANT_IF/GRANT_DM`.
- Sub-module `mem_lane_align`, combinational:
  - Inputs: memop, we, offset, wdata, rdata.
  - Outputs: wdata_sh, wmask, rdata_ext, misalign/illegal flags.
- `mem_arbiter` holds the FSM, the registers, and one `mem_lane_align` instance.

## Test plan
- **DM byte store:** `dm_we`=1, `MEM_B`, addr 0x1003, wdata 0xAB; mem_ack after 2 cycles → `mem_addr`=0x1000, `mem_wmask`=0x08, `mem_wdata`=0xAB000000, `dm_ack` 1 cycle after mem_ack, `dm_err`=0.
- **Load extension:** `mem_rdata`=0x80FF_0000_0000_0000; `MEM_H` @0x2006 → `dm_rdata`=0xFFFF_FFFF_FFFF_80FF; `MEM_UH` → 0x80FF.
- **Simultaneous requests after reset:** IF @0x0, DM load @0x100, both held → DM granted first, IF next; repeat pair → DM granted first again (round-robin), 1 transaction per grant.
- **Error paths:** `MEM_W` @0x2 and store `MEM_UB` → `dm_ack`+`dm_err`=1 one cycle after request, `mem_req` never asserted. IF @0x6 → `if_err`=1.
- **Fetch:** IF @0x104, `mem_rdata`=0x11223344_55667788 → `mem_addr`=0x100, `if_rdata`=0x11223344.
- **Reset mid-op:** rst during `D_WAIT` with `mem_req`=1 → `mem_req`=0 immediately, no ack. After release, a stray `mem_ack` produces no ack, and state stays `IDLE`.
